uart_rx_oversampler: RTL and testbench
======================================

UART_RX_OVERSAMPLER -- requirements
Module: uart_rx_oversampler

Interface
REQ-001 Parameter CLK_FREQ, default 1_600_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 10_000, line bit rate in bit/s.
REQ-003 Parameter OVS, default 16, samples per bit; legal values are even and at least 8.
REQ-004 Port clk  input  1  system clock; all logic SHALL use rising edges only.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port rx  input  1  asynchronous serial line; idles high.
REQ-007 Port out_ready  input  1  consumer (fifo write side) can accept a byte.
REQ-008 Port data_out  output  8  received byte, LSB-first assembly.
REQ-009 Port valid  output  1  data_out holds an unconsumed byte.
REQ-010 Port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 Port overrun  output  1  one-cycle pulse: a byte completed while the previous byte was unconsumed.
REQ-012 Port busy  output  1  high in every state except IDLE.

Function
REQ-013 The sample-tick divider SHALL be DIV = CLK_FREQ/(BAUD*OVS), integer-truncated, minimum 1, and SHALL emit a one-clock tick every DIV clocks.
REQ-014 rx SHALL pass through a 2-flop synchronizer before use; the synchronizer flops reset to 1.
REQ-015 State machine states are IDLE, START, DATA, PARITY (present only with the macro) and STOP.
REQ-016 IDLE: on a synchronized rx of 0, go to START and clear the divider and sample counter in the same cycle.
REQ-017 Each bit value SHALL be the 2-of-3 majority of the samples taken at ticks OVS/2-1, OVS/2 and OVS/2+1 of that bit.
REQ-018 START: if the majority is 1 (glitch), return to IDLE with no output; otherwise go to DATA at tick OVS-1.
REQ-019 DATA: shift in 8 bits LSB-first; after bit 7 go to PARITY if the macro is defined, otherwise go to STOP.
REQ-020 STOP: decide the stop bit at sample tick OVS/2+1, then return to IDLE that same cycle, so the next start edge is accepted mid-stop-bit.
REQ-021 Stop bit 1: on the next clock, load data_out and set valid; stop bit 0: pulse frame_err, and leave valid and data_out unchanged.
REQ-022 valid SHALL stay high until a cycle with out_ready=1, and then drop on the next clock.
REQ-023 A byte completing while valid=1 and out_ready=0 SHALL be dropped with an overrun pulse; data_out keeps the old byte.
REQ-024 A byte completing in the same cycle out_ready=1 consumes the old byte SHALL load the new byte, keep valid high, and raise no overrun.
REQ-025 data_out SHALL be stable whenever valid=1.

Reset
REQ-026 When rst=1 at a clock edge: state=IDLE, divider and counters=0, shift register=0, data_out=8'h00, valid=0, frame_err=0, overrun=0, busy=0, parity_err=0.
REQ-027 Reset in mid-frame SHALL abandon the frame with no pulse; reception restarts on the first falling edge after rst deasserts.

Configuration
REQ-028 With UART_RX_PARITY_EN defined: the PARITY state samples one even-parity bit; an output port parity_err (1 bit) is added; a mismatch pulses parity_err for one cycle at the cycle where valid would rise, and the byte is discarded.
REQ-029 Without UART_RX_PARITY_EN: no parity bit, no PARITY state and no parity_err port; the frame is 8N1.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum type, the constant DATA_BITS=8 and the helper function that computes the divider.
REQ-031 Sub-module uart_baud_tick (divider plus tick output, with a synchronous clear input) SHALL be used; all other logic is in this module.

Verification (CLK_FREQ=1_600_000, BAUD=10_000, OVS=16, so DIV=10 and one bit = 160 clk)
REQ-032 Send 8'h55 in 8N1 with out_ready=1 -> valid rises 1 clk after the mid-stop-bit decision, with data_out=8'h55, and there is no frame_err.
REQ-033 Drive rx low for 40 clk, then high -> return to IDLE, valid stays 0, no pulses.
REQ-034 Send 8'hA3 with the stop bit forced low -> a single frame_err pulse, valid=0.
REQ-035 With out_ready=0, send 8'h12 then 8'h34 back-to-back -> data_out=8'h12 held, one overrun pulse at the end of the second byte.
REQ-036 Assert rst for 1 clk in the middle of data bit 3 of 8'hFF, then send 8'h0F -> only 8'h0F is delivered.
REQ-037 With UART_RX_PARITY_EN defined, send 8'h07 with parity bit 0 -> a parity_err pulse, no valid.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- shared definitions for the oversampling UART receiver.
//
// Contents:
//   DATA_BITS   : payload bits per frame
//   rx_state_e  : receiver FSM state encoding; the PARITY state exists only
//                 when UART_RX_PARITY_EN is defined
//   calc_div    : sample-tick divider from clock, baud and oversampling ratio
//
// Optional feature macro: UART_RX_PARITY_EN
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_e;

  // Integer-truncated clocks per sample tick, never below one.
  function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
    int d;
    d = clk_freq / (baud * ovs);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick -- sample-tick divider.
//
// Emits a one-clock tick every DIV clocks. A synchronous clear restarts the
// count so that the first tick after clear arrives DIV clocks later.
//
// Ports:
//   clk   in  system clock (rising edge)
//   rst   in  synchronous active-high reset
//   clr   in  synchronous counter clear (suppresses the tick in that cycle)
//   tick  out one-cycle sample tick
// -----------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a value on every path, which keeps
  // this block purely combinational; a missing default would infer a latch.
  always_comb begin
    tick  = !clr && (cnt_q == LAST);
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_oversampler.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampler -- oversampling UART receiver (8N1, optional even parity).
//
// The line is synchronized, sampled OVS times per bit, and each bit value is
// the 2-of-3 majority of the samples around mid-bit. A completed byte is held
// in data_out with valid until the consumer takes it with out_ready.
//
// Parameters: CLK_FREQ (Hz), BAUD (bit/s), OVS (samples per bit, even, >= 8)
//
// Ports:
//   clk        in  system clock (rising edge only)
//   rst        in  synchronous active-high reset
//   rx         in  asynchronous serial line, idles high
//   out_ready  in  consumer can accept a byte
//   data_out   out received byte (stable while valid)
//   valid      out data_out holds an unconsumed byte
//   frame_err  out one-cycle pulse: stop bit sampled low
//   overrun    out one-cycle pulse: byte dropped because previous unconsumed
//   busy       out receiver is not idle
//   parity_err out one-cycle pulse: even-parity mismatch (UART_RX_PARITY_EN only)
//
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit, the PARITY
// state and the parity_err port. Without it the frame is 8N1.
// -----------------------------------------------------------------------------
module uart_rx_oversampler
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 1_600_000,
  parameter int BAUD     = 10_000,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       out_ready,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int            DIV     = calc_div(CLK_FREQ, BAUD, OVS);
  localparam int            SW      = $clog2(OVS);
  localparam logic [SW-1:0] S_EARLY = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_MID   = SW'(OVS / 2);
  localparam logic [SW-1:0] S_LATE  = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] S_LAST  = SW'(OVS - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  rx_state_e              state_q, state_d;
  logic                   rx_meta_q, rx_meta_d;
  logic                   rx_sync_q, rx_sync_d;
  logic [SW-1:0]          sample_cnt_q, sample_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [1:0]             samp_q, samp_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bit_q, parity_bit_d;
  logic                   parity_err_q, parity_err_d;
`endif

  logic tick;
  logic tick_clr;
  logic maj;
  logic byte_done;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Third sample is the live synchronized line at tick OVS/2+1.
  assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);

  always_comb begin
    state_d      = state_q;
    rx_meta_d    = rx;
    rx_sync_d    = rx_meta_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    valid_d      = valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    tick_clr     = 1'b0;
    byte_done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_err_d = 1'b0;
`endif

    // Consumer handshake: a cycle with out_ready drops valid on the next clock.
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (tick) begin
      sample_cnt_d = (sample_cnt_q == S_LAST) ? '0 : sample_cnt_q + SW'(1);
      if (sample_cnt_q == S_EARLY) samp_d[0] = rx_sync_q;
      if (sample_cnt_q == S_MID)   samp_d[1] = rx_sync_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          // Align the bit timing to the detected start edge.
          state_d      = ST_START;
          tick_clr     = 1'b1;
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
        end
      end

      ST_START: begin
        if (tick && sample_cnt_q == S_LATE && maj) begin
          state_d = ST_IDLE;
        end else if (tick && sample_cnt_q == S_LAST) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (tick && sample_cnt_q == S_LATE) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
        end
        if (tick && sample_cnt_q == S_LAST) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick && sample_cnt_q == S_LATE) begin
          parity_bit_d = maj;
        end
        if (tick && sample_cnt_q == S_LAST) begin
          state_d = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        // Decide mid-stop-bit and go idle at once so a start edge arriving
        // during the tail of the stop bit is not missed.
        if (tick && sample_cnt_q == S_LATE) begin
          state_d = ST_IDLE;
          if (!maj) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if ((^shift_q) != parity_bit_q) begin
            parity_err_d = 1'b1;
`endif
          end else begin
            byte_done = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Accept the new byte if the slot is empty or being emptied this cycle;
    // otherwise keep the old byte and flag the loss.
    if (byte_done) begin
      if (!valid_q || out_ready) begin
        data_out_d = shift_q;
        valid_d    = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      samp_q       <= '0;
      // NOTE: the shift register and output byte are ordinary flops, not a
      // memory array, so they take a defined reset value like everything else.
      shift_q      <= '0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out  = data_out_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversampler -- self-checking bench for uart_rx_oversampler.
// Default parameters: DIV=10, 160 clk per bit. A table of single frames is
// applied in a loop, followed by hand-written multi-frame sequences.
// -----------------------------------------------------------------------------
module tb_uart_rx_oversampler;

  localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Start drive -> stop-bit decision at tick 9 of the last bit (2 sync clocks,
  // 1 clock to START, first tick 10 clocks later), then one clock to valid.
  localparam int LAT = (NBITS - 1) * BIT_CLKS + 103;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       out_ready = 1'b1;
  logic [7:0] data_out;
  logic       valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_oversampler #(
    .CLK_FREQ (1_600_000),
    .BAUD     (10_000),
    .OVS      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .valid      (valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge.
  int         rise_cnt = 0, rise_cyc = 0, ferr_cnt = 0, ovr_cnt = 0, ovr_cyc = 0, perr_cnt = 0;
  logic [7:0] rise_data = 8'h00;
  logic       prev_valid = 1'b0;
  always @(negedge clk) begin
    prev_valid <= valid;
    if (valid && !prev_valid) begin
      rise_cnt  <= rise_cnt + 1;
      rise_cyc  <= cyc;
      rise_data <= data_out;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun) begin
      ovr_cnt <= ovr_cnt + 1;
      ovr_cyc <= cyc;
    end
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt <= perr_cnt + 1;
`endif
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int b_rise, b_ferr, b_ovr, b_perr;
  task automatic snap();
    b_rise = rise_cnt;
    b_ferr = ferr_cnt;
    b_ovr  = ovr_cnt;
    b_perr = perr_cnt;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at a falling edge. ready_off / rst_off (clock
  // offsets from the start edge, -1 = unused) pulse out_ready / rst for one clk.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_good,
                            input int ready_off, input int rst_off, output int start_cyc);
    logic bits [NBITS];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
`ifdef UART_RX_PARITY_EN
    bits[9] = par_good ? ^d : ~(^d);
`endif
    bits[NBITS - 1] = stop_bit;
    @(negedge clk);
    start_cyc = cyc;
    for (int b = 0; b < NBITS; b++) begin
      for (int k = 0; k < BIT_CLKS; k++) begin
        int off;
        off = b * BIT_CLKS + k;
        rx = bits[b];
        if (ready_off >= 0 && off == ready_off)     out_ready = 1'b1;
        if (ready_off >= 0 && off == ready_off + 1) out_ready = 1'b0;
        if (rst_off >= 0 && off == rst_off)         rst = 1'b1;
        if (rst_off >= 0 && off == rst_off + 1)     rst = 1'b0;
        @(negedge clk);
      end
    end
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_rises;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [6];
  int   s0, s1;

  initial begin
    vecs[0] = '{data: 8'h55, stop_bit: 1'b1, exp_rises: 1, exp_ferr: 0};
    vecs[1] = '{data: 8'h00, stop_bit: 1'b1, exp_rises: 1, exp_ferr: 0};
    vecs[2] = '{data: 8'hFF, stop_bit: 1'b1, exp_rises: 1, exp_ferr: 0};
    vecs[3] = '{data: 8'hA3, stop_bit: 1'b0, exp_rises: 0, exp_ferr: 1};
    vecs[4] = '{data: 8'h80, stop_bit: 1'b1, exp_rises: 1, exp_ferr: 0};
    vecs[5] = '{data: 8'h3C, stop_bit: 1'b1, exp_rises: 1, exp_ferr: 0};

    // Reset state
    idle(4);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle(20);

    // Table of single frames, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      snap();
      send_frame(vecs[i].data, vecs[i].stop_bit, 1'b1, -1, -1, s0);
      idle(100);
      check($sformatf("v%0d_rises", i), rise_cnt - b_rise, vecs[i].exp_rises);
      check($sformatf("v%0d_ferr", i), ferr_cnt - b_ferr, vecs[i].exp_ferr);
      check($sformatf("v%0d_ovr", i), ovr_cnt - b_ovr, 0);
      check($sformatf("v%0d_valid_after", i), valid, 1'b0);
      check($sformatf("v%0d_busy_after", i), busy, 1'b0);
      if (vecs[i].exp_rises != 0) begin
        check($sformatf("v%0d_data", i), rise_data, vecs[i].data);
        check($sformatf("v%0d_latency", i), rise_cyc - s0, LAT);
      end
    end

    // Start glitch: 40 clk low, then high
    snap();
    @(negedge clk);
    rx = 1'b0;
    idle(20);
    check("glitch_busy_mid", busy, 1'b1);
    idle(20);
    rx = 1'b1;
    idle(200);
    check("glitch_busy_after", busy, 1'b0);
    check("glitch_rises", rise_cnt - b_rise, 0);
    check("glitch_ferr", ferr_cnt - b_ferr, 0);
    check("glitch_valid", valid, 1'b0);

    // Overrun: two frames with nobody consuming
    out_ready = 1'b0;
    snap();
    send_frame(8'h12, 1'b1, 1'b1, -1, -1, s0);
    send_frame(8'h34, 1'b1, 1'b1, -1, -1, s1);
    idle(50);
    check("ovr_rises", rise_cnt - b_rise, 1);
    check("ovr_count", ovr_cnt - b_ovr, 1);
    check("ovr_timing", ovr_cyc - s1, LAT);
    check("ovr_data_held", data_out, 8'h12);
    check("ovr_valid_held", valid, 1'b1);
    // Drain: valid drops on the clock after the out_ready cycle
    out_ready = 1'b1;
    check("drain_valid_before", valid, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_valid_after", valid, 1'b0);
    idle(20);

    // Byte completes in the same cycle the old byte is consumed
    snap();
    send_frame(8'h5A, 1'b1, 1'b1, -1, -1, s0);
    idle(20);
    check("same_first_data", data_out, 8'h5A);
    send_frame(8'hC3, 1'b1, 1'b1, LAT - 1, -1, s1);
    idle(20);
    check("same_data", data_out, 8'hC3);
    check("same_valid", valid, 1'b1);
    check("same_ovr", ovr_cnt - b_ovr, 0);
    out_ready = 1'b1;
    idle(5);
    check("same_drained", valid, 1'b0);

    // Reset during data bit 3 of 0xFF, then 0x0F
    snap();
    send_frame(8'hFF, 1'b1, 1'b1, -1, 4 * BIT_CLKS + 80, s0);
    send_frame(8'h0F, 1'b1, 1'b1, -1, -1, s1);
    idle(100);
    check("rst_mid_rises", rise_cnt - b_rise, 1);
    check("rst_mid_data", rise_data, 8'h0F);
    check("rst_mid_latency", rise_cyc - s1, LAT);
    check("rst_mid_ferr", ferr_cnt - b_ferr, 0);

`ifdef UART_RX_PARITY_EN
    // Bad even parity on 0x07
    snap();
    send_frame(8'h07, 1'b1, 1'b0, -1, -1, s0);
    idle(100);
    check("par_err", perr_cnt - b_perr, 1);
    check("par_rises", rise_cnt - b_rise, 0);
    check("par_ferr", ferr_cnt - b_ferr, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
